serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parametrised successor to the team's 5-bit count-driven serial transmitter.
- Owns its own bit-timing counter and shift register instead of taking an external count.
- Frames parallel data with a start bit, LSB-first data, optional even parity, a stop bit and an inter-frame gap.
- Sits between the remote's button/encoder logic and the IR/serial line driver; upstream hands words over on a valid/ready handshake.

Parameters:
- DATA_W, 5: payload width in bits; must be >= 1.
- CLKS_PER_BIT, 16: clock cycles per line bit; must be >= 1.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits; 0 omits it.
- GAP_BITS, 2: idle-level bit periods after the stop bit before the next word can be accepted; may be 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_W  payload word; sampled only on acceptance.
- tx_valid  input  1  upstream has a word to send.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- serial_data  output  1  registered line output; idle level is 1.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse marking completion of a frame, including its gap.

Behaviour:
- Reset (async assert, sync release): state=IDLE, serial_data=1, busy=0, tx_done=0, all counters 0. tx_ready is 1 while reset is deasserted.
- tx_ready = (state==IDLE), decoded combinationally from the state register. busy = ~tx_ready.
- Acceptance happens on a rising edge where tx_valid && tx_ready.
  - That edge latches tx_data into the shift register.
  - It computes parity = ^tx_data.
  - It moves the state to START and drives serial_data=0.
- States:
  - IDLE: serial_data=1.
  - START: serial_data=0.
  - DATA: serial_data = shift register LSB; bits are sent LSB first.
  - PARITY: serial_data = latched parity bit.
  - STOP: serial_data=1.
  - GAP: serial_data=1.
- Bit timing:
  - Every non-IDLE state holds each line bit for exactly CLKS_PER_BIT cycles.
  - The bit-period counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Transitions, taken at the end of a bit period:
  - START -> DATA.
  - DATA -> DATA until DATA_W bits have been sent. Shift right once per bit; the bit-index counter runs 0..DATA_W-1.
  - DATA -> PARITY if PARITY_EN=1, else DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> GAP if GAP_BITS>0, else STOP -> IDLE.
  - GAP -> IDLE after GAP_BITS bit periods.
- Frame length: F = 1 + DATA_W + PARITY_EN + 1 + GAP_BITS bit periods. The state returns to IDLE exactly F*CLKS_PER_BIT edges after the acceptance edge.
- tx_done: high for exactly the first cycle in IDLE after a frame. It is never asserted after reset alone.
- Back-to-back operation:
  - With tx_valid held high, the next acceptance occurs on the edge following the IDLE entry edge.
  - Frame-to-frame period is therefore F*CLKS_PER_BIT + 1 cycles.
  - During that single IDLE cycle serial_data=1.
- tx_data and tx_valid changes while busy are ignored. The in-flight frame is unaffected.
- CLKS_PER_BIT=1: every state lasts one cycle; no special cases.
- Reset mid-frame: serial_data goes to 1 and the state goes to IDLE immediately and asynchronously. The partial frame is abandoned, no tx_done is generated, and the word is not retransmitted.
- Counter widths: $clog2 of the terminal value, with a minimum of 1 bit. No arithmetic overflow is permitted at any parameter value.

Test Plan:
1. Defaults (DATA_W=5, CLKS_PER_BIT=16, PARITY_EN=0, GAP_BITS=2), reset then send 5'b10110.
   - Line after acceptance: 0 x16, then 0,1,1,0,1 each x16, then 1 x16 stop, then 1 x32 gap.
   - tx_ready returns 144 cycles after acceptance, with a single tx_done pulse.
2. DATA_W=5, CLKS_PER_BIT=4, PARITY_EN=1, GAP_BITS=2; send 5'b10110.
   - Parity bit=1, held for 4 cycles after the MSB.
   - IDLE is re-entered 40 edges after acceptance.
3. Same configuration as scenario 2, send 5'b00000.
   - Parity bit=0.
   - Line is 0 for 28 cycles (start + data + parity), then 1.
4. tx_valid held high, with 5'h15 then 5'h0A presented.
   - Two frames 41 cycles apart, with one IDLE cycle between them.
   - Changing tx_data mid-frame does not alter the bits on the line.
5. Assert rst_n=0 during the third data bit of a frame.
   - serial_data=1 and tx_ready=1 without waiting for a clock edge.
   - No tx_done; the next accepted word transmits cleanly from its start bit.
6. CLKS_PER_BIT=1, GAP_BITS=0, DATA_W=8; send 8'hA5.
   - Line is 0,1,0,1,0,0,1,0,1,1, one cycle each.
   - tx_done is asserted 10 cycles after acceptance.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Frames a parallel word for a serial line. Each frame is a start bit (0),
//   DATA_W data bits LSB first, an optional even-parity bit, a stop bit (1)
//   and GAP_BITS idle-level bit periods. Every line bit is held for
//   CLKS_PER_BIT clocks. Words arrive on a valid/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   tx_data      payload word, sampled only on acceptance
//   tx_valid     upstream has a word to send
//   tx_ready     block can accept a word (IDLE only)
//   serial_data  registered line output, idle level 1
//   busy         high whenever not IDLE
//   tx_done      one-cycle pulse on the first IDLE cycle after a frame
module serial_frame_tx #(
    parameter int DATA_W       = 5,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int GAP_BITS     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_data,
    output logic              busy,
    output logic              tx_done
);

    // The index counter is shared between the data bits and the gap periods,
    // so it is sized for whichever of the two runs longer.
    localparam int IDX_MAX = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
    localparam int CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW      = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);
    localparam logic [IW-1:0] GAP_LAST  = IW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     bit_q, bit_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              serial_q, serial_d;
    logic              done_q, done_d;
    logic              bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_end = (bit_q == BIT_LAST);

        if (state_q != IDLE) begin
            bit_d = bit_end ? '0 : bit_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
                    par_d   = ^tx_data;
                    bit_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = (GAP_BITS > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (idx_q == GAP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The line register is loaded with the level belonging to the next
    // state, so the output changes on the same edge as the state does.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_d;
            default: serial_d = 1'b1;
        endcase
        done_d = (state_d == IDLE) && (state_q != IDLE);
    end

    assign tx_ready    = (state_q == IDLE);
    assign busy        = ~tx_ready;
    assign serial_data = serial_q;
    assign tx_done     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

    logic       clk;
    logic       rst_n;
    logic [4:0] d0, d1;
    logic [7:0] d2;
    logic [2:0] vld;
    logic [2:0] rdy, ser, bsy, dn;
    int         errors;
    int         checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // u0: defaults; u1: CLKS_PER_BIT=4 with parity; u2: 8-bit, one clock per bit, no gap
    serial_frame_tx u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(vld[0]), .tx_ready(rdy[0]),
        .serial_data(ser[0]), .busy(bsy[0]), .tx_done(dn[0])
    );

    serial_frame_tx #(.DATA_W(5), .CLKS_PER_BIT(4), .PARITY_EN(1), .GAP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(vld[1]), .tx_ready(rdy[1]),
        .serial_data(ser[1]), .busy(bsy[1]), .tx_done(dn[1])
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .GAP_BITS(0)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(vld[2]), .tx_ready(rdy[2]),
        .serial_data(ser[2]), .busy(bsy[2]), .tx_done(dn[2])
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int inst, input logic [7:0] v, input logic val);
        case (inst)
            0: begin d0 = v[4:0]; vld[0] = val; end
            1: begin d1 = v[4:0]; vld[1] = val; end
            default: begin d2 = v; vld[2] = val; end
        endcase
    endtask

    // Called on a negedge with the instance idle. Sends one word and checks
    // the line period by period against the hand-written expected bits
    // (line[i] = level of bit period i). With keep set, tx_valid stays high
    // so the caller can chain the next frame on the single IDLE cycle.
    // tx_data is scrambled partway through to show it is ignored while busy.
    task automatic frame(input string name, input int inst, input logic [7:0] data,
                         input int nper, input int cpb, input logic [15:0] line,
                         input bit keep);
        logic [7:0] cur;
        cur = data;
        chk({name, " ready_before"}, 16'(rdy[inst]), 16'd1);
        set_in(inst, cur, 1'b1);
        @(posedge clk);
        for (int n = 0; n < nper * cpb; n++) begin
            @(negedge clk);
            if (n == 0 && !keep) set_in(inst, cur, 1'b0);
            if (n == 2 * cpb) begin
                cur = ~data;
                set_in(inst, cur, keep);
            end
            chk($sformatf("%s line[%0d]", name, n), 16'(ser[inst]), 16'(line[n / cpb]));
            chk($sformatf("%s done_low[%0d]", name, n), 16'(dn[inst]), 16'd0);
            if (n == 0) begin
                chk({name, " busy_in_frame"}, 16'(bsy[inst]), 16'd1);
                chk({name, " ready_in_frame"}, 16'(rdy[inst]), 16'd0);
            end
        end
        @(negedge clk);
        chk({name, " ready_end"}, 16'(rdy[inst]), 16'd1);
        chk({name, " done_end"}, 16'(dn[inst]), 16'd1);
        chk({name, " line_end"}, 16'(ser[inst]), 16'd1);
        chk({name, " busy_end"}, 16'(bsy[inst]), 16'd0);
        if (!keep) begin
            @(negedge clk);
            chk({name, " done_single"}, 16'(dn[inst]), 16'd0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        vld    = 3'b000;
        d0     = '0;
        d1     = '0;
        d2     = '0;
        repeat (3) @(negedge clk);
        chk("reset ready", 16'(rdy), 16'h7);
        chk("reset line", 16'(ser), 16'h7);
        chk("reset busy", 16'(bsy), 16'h0);
        chk("reset done", 16'(dn), 16'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset ready", 16'(rdy), 16'h7);
        chk("post_reset done", 16'(dn), 16'h0);
        chk("post_reset line", 16'(ser), 16'h7);

        // Defaults, 5'b10110: start, 0 1 1 0 1, stop, two gap periods (144 clocks)
        frame("s1", 0, 8'h16, 9, 16, 16'b1_1110_1100, 1'b0);

        // Parity on, 5'b10110: parity bit 1 after the MSB (40 clocks)
        frame("s2", 1, 8'h16, 10, 4, 16'b11_1110_1100, 1'b0);

        // Parity on, all-zero word: line 0 for 28 clocks then 1
        frame("s3", 1, 8'h00, 10, 4, 16'b11_1000_0000, 1'b0);

        // Back-to-back with tx_valid held high: 5'h15 then 5'h0A, 41 clocks apart
        frame("s4a", 1, 8'h15, 10, 4, 16'b11_1110_1010, 1'b1);
        frame("s4b", 1, 8'h0A, 10, 4, 16'b11_1001_0100, 1'b0);

        // Reset during the third data bit (bit period 3 spans clocks 12..15)
        set_in(1, 8'h16, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_in(1, 8'h16, 1'b0);
        repeat (13) @(negedge clk);
        chk("s5 busy_before_reset", 16'(bsy[1]), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5 async line", 16'(ser[1]), 16'd1);
        chk("s5 async ready", 16'(rdy[1]), 16'd1);
        chk("s5 async busy", 16'(bsy[1]), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("s5 no_done[%0d]", i), 16'(dn[1]), 16'd0);
            chk($sformatf("s5 idle_line[%0d]", i), 16'(ser[1]), 16'd1);
        end
        frame("s5 resend", 1, 8'h16, 10, 4, 16'b11_1110_1100, 1'b0);

        // One clock per bit, 8'hA5, no gap: 0,1,0,1,0,0,1,0,1,1 then tx_done
        frame("s6", 2, 8'hA5, 10, 1, 16'b11_0100_1010, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule
